dmem_dual_responder: RTL and testbench

Responder side of the dual-issue data-memory interface. It accepts up to two load/store requests per cycle, one from slot 1 and one from slot 2, and returns registered load data for each slot. Slot 1 is always the older instruction, and same-cycle hazards between the slots resolve in program order. After reset it runs a sequential clear sweep and only accepts requests once the sweep completes.

---
 rtl/dmem_dual_responder_if.sv | 40 ++++
 rtl/dmem_dual_responder.sv | 132 +++++++++++++
 tb/tb_dmem_dual_responder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dmem_dual_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_dual_responder_if : dual-slot load/store bus between core and dmem  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface dmem_dual_responder_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64
);
  logic [63:0]           inputAddress1;
  logic [DATA_WIDTH-1:0] inputData1;
  logic                  CONTROL_MemWrite1;
  logic                  CONTROL_MemRead1;
  logic [63:0]           inputAddress2;
  logic [DATA_WIDTH-1:0] inputData2;
  logic                  CONTROL_MemWrite2;
  logic                  CONTROL_MemRead2;
  logic [DATA_WIDTH-1:0] outputData1;
  logic [DATA_WIDTH-1:0] outputData2;
  logic                  outputValid1;
  logic                  outputValid2;
  logic                  ready;
  logic                  error1;
  logic                  error2;

  modport master (
    output inputAddress1, inputData1, CONTROL_MemWrite1, CONTROL_MemRead1,
    output inputAddress2, inputData2, CONTROL_MemWrite2, CONTROL_MemRead2,
    input  outputData1, outputData2, outputValid1, outputValid2,
    input  ready, error1, error2
  );

  modport slave (
    input  inputAddress1, inputData1, CONTROL_MemWrite1, CONTROL_MemRead1,
    input  inputAddress2, inputData2, CONTROL_MemWrite2, CONTROL_MemRead2,
    output outputData1, outputData2, outputValid1, outputValid2,
    output ready, error1, error2
  );
endinterface
`default_nettype wire

// File: rtl/dmem_dual_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_dual_responder : two-slot data memory, slot 1 older, clear on reset |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dmem_dual_responder #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  dmem_dual_responder_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_idx_q, clr_idx_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [DATA_WIDTH-1:0]   out_data1_q, out_data1_d;
  logic [DATA_WIDTH-1:0]   out_data2_q, out_data2_d;
  logic                    out_valid1_q, out_valid1_d;
  logic                    out_valid2_q, out_valid2_d;
  logic                    error1_q, error1_d;
  logic                    error2_q, error2_d;
  logic                    ready_q, ready_d;

  logic [ADDR_WIDTH-1:0]   w_idx1, w_idx2;
  logic                    w_bad1, w_bad2;
  logic                    w_acc_rd1, w_acc_wr1, w_acc_rd2, w_acc_wr2;
  logic                    w_we_a, w_we_b;
  logic [ADDR_WIDTH-1:0]   w_wa_idx;
  logic [DATA_WIDTH-1:0]   w_wa_data;
  logic                    w_active;

  always_comb begin
    w_active = (state_q == ST_READY);
    w_idx1   = bus.inputAddress1[ADDR_WIDTH+2:3];
    w_idx2   = bus.inputAddress2[ADDR_WIDTH+2:3];

    w_bad1 = (bus.inputAddress1[2:0] != 3'd0)
           | (bus.inputAddress1[63:ADDR_WIDTH+3] != '0)
           | (bus.CONTROL_MemRead1 & bus.CONTROL_MemWrite1);
    w_bad2 = (bus.inputAddress2[2:0] != 3'd0)
           | (bus.inputAddress2[63:ADDR_WIDTH+3] != '0)
           | (bus.CONTROL_MemRead2 & bus.CONTROL_MemWrite2);

    w_acc_rd1 = w_active & ~w_bad1 & bus.CONTROL_MemRead1;
    w_acc_wr1 = w_active & ~w_bad1 & bus.CONTROL_MemWrite1;
    w_acc_rd2 = w_active & ~w_bad2 & bus.CONTROL_MemRead2;
    w_acc_wr2 = w_active & ~w_bad2 & bus.CONTROL_MemWrite2;

    error1_d = w_active & w_bad1 & (bus.CONTROL_MemRead1 | bus.CONTROL_MemWrite1);
    error2_d = w_active & w_bad2 & (bus.CONTROL_MemRead2 | bus.CONTROL_MemWrite2);

    // Port A is shared between the clear sweep and slot-1 stores.
    if (state_q == ST_CLEAR) begin
      w_we_a    = 1'b1;
      w_wa_idx  = clr_idx_q;
      w_wa_data = '0;
    end else begin
      w_we_a    = w_acc_wr1;
      w_wa_idx  = w_idx1;
      w_wa_data = bus.inputData1;
    end
    w_we_b = w_acc_wr2;

    out_valid1_d = w_acc_rd1;
    out_valid2_d = w_acc_rd2;
    out_data1_d  = w_acc_rd1 ? mem_q[w_idx1] : out_data1_q;
    out_data2_d  = out_data2_q;
    if (w_acc_rd2) begin
      // An older slot-1 store to the same entry is forwarded to the slot-2 load.
      if (w_acc_wr1 && (w_idx1 == w_idx2)) out_data2_d = bus.inputData1;
      else                                 out_data2_d = mem_q[w_idx2];
    end

    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == ST_CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == ADDR_WIDTH'(DEPTH - 1)) state_d = ST_READY;
    end
    ready_d = (state_d == ST_READY);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q      <= ST_CLEAR;
      clr_idx_q    <= '0;
      out_data1_q  <= '0;
      out_data2_q  <= '0;
      out_valid1_q <= 1'b0;
      out_valid2_q <= 1'b0;
      error1_q     <= 1'b0;
      error2_q     <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      out_data1_q  <= out_data1_d;
      out_data2_q  <= out_data2_d;
      out_valid1_q <= out_valid1_d;
      out_valid2_q <= out_valid2_d;
      error1_q     <= error1_d;
      error2_q     <= error2_d;
      ready_q      <= ready_d;
    end
  end

  // Slot-2 store is applied last so it wins a same-entry collision with slot 1.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      if (w_we_a) mem_q[w_wa_idx] <= w_wa_data;
      if (w_we_b) mem_q[w_idx2]   <= bus.inputData2;
    end
  end

  assign bus.outputData1  = out_data1_q;
  assign bus.outputData2  = out_data2_q;
  assign bus.outputValid1 = out_valid1_q;
  assign bus.outputValid2 = out_valid2_q;
  assign bus.error1       = error1_q;
  assign bus.error2       = error2_q;
  assign bus.ready        = ready_q;
endmodule
`default_nettype wire

// File: tb/tb_dmem_dual_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_dual_responder : random + directed bench with a reference model  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_dmem_dual_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_dual_responder_if #(.ADDR_WIDTH(6), .DATA_WIDTH(64)) bus ();

  dmem_dual_responder #(.ADDR_WIDTH(6), .DATA_WIDTH(64)) dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [63:0] m_mem [64];
  int          m_cnt;
  bit          m_rdy;
  logic [63:0] e_d1, e_d2;
  bit          e_v1, e_v2, e_e1, e_e2;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [63:0] a, input bit r, input bit w);
    return (a[2:0] == 3'd0) && (a[63:9] == '0) && !(r && w);
  endfunction

  task automatic model_edge(input bit r,
                            input logic [63:0] a1, input logic [63:0] d1, input bit w1, input bit rd1,
                            input logic [63:0] a2, input logic [63:0] d2, input bit w2, input bit rd2);
    bit ok1, ok2;
    int i1, i2;
    if (r) begin
      m_cnt = 0; m_rdy = 0;
      e_v1 = 0; e_v2 = 0; e_e1 = 0; e_e2 = 0; e_d1 = '0; e_d2 = '0;
      foreach (m_mem[k]) m_mem[k] = '0;
    end else if (!m_rdy) begin
      m_cnt++;
      if (m_cnt == 64) m_rdy = 1;
      e_v1 = 0; e_v2 = 0; e_e1 = 0; e_e2 = 0;
    end else begin
      ok1 = legal(a1, rd1, w1);
      ok2 = legal(a2, rd2, w2);
      i1 = int'(a1[8:3]);
      i2 = int'(a2[8:3]);
      e_e1 = (rd1 || w1) && !ok1;
      e_e2 = (rd2 || w2) && !ok2;
      e_v1 = rd1 && ok1;
      e_v2 = rd2 && ok2;
      if (e_v1) e_d1 = m_mem[i1];
      if (e_v2) e_d2 = (w1 && ok1 && i1 == i2) ? d1 : m_mem[i2];
      if (w1 && ok1) m_mem[i1] = d1;
      if (w2 && ok2) m_mem[i2] = d2;
    end
  endtask

  task automatic cyc(input bit r,
                     input logic [63:0] a1, input logic [63:0] d1, input bit w1, input bit rd1,
                     input logic [63:0] a2, input logic [63:0] d2, input bit w2, input bit rd2);
    rst = r;
    bus.inputAddress1 = a1; bus.inputData1 = d1;
    bus.CONTROL_MemWrite1 = w1; bus.CONTROL_MemRead1 = rd1;
    bus.inputAddress2 = a2; bus.inputData2 = d2;
    bus.CONTROL_MemWrite2 = w2; bus.CONTROL_MemRead2 = rd2;
    @(posedge clk);
    model_edge(r, a1, d1, w1, rd1, a2, d2, w2, rd2);
    #1;
    check("ready",  64'(bus.ready),        64'(m_rdy));
    check("valid1", 64'(bus.outputValid1), 64'(e_v1));
    check("valid2", 64'(bus.outputValid2), 64'(e_v2));
    check("error1", 64'(bus.error1),       64'(e_e1));
    check("error2", 64'(bus.error2),       64'(e_e2));
    check("data1",  bus.outputData1,       e_d1);
    check("data2",  bus.outputData2,       e_d2);
  endtask

  task automatic idle(input bit r, input int n);
    for (int k = 0; k < n; k++) cyc(r, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    int sel;
    sel = int'($urandom_range(0, 15));
    a = 64'($urandom_range(0, 7)) << 3;
    if (sel == 0) a = a | 64'($urandom_range(1, 7));
    else if (sel == 1) a = a | (64'h200 << $urandom_range(0, 54));
    return a;
  endfunction

  initial begin
    logic [63:0] a1, a2;
    bit w1, r1, w2, r2, rr;

    // Reset sweep and first read of the last entry
    idle(1, 2);
    idle(0, 64);
    cyc(0, 64'h1F8, 0, 0, 1, 0, 0, 0, 0);
    idle(0, 1);

    // Basic store/load
    cyc(0, 64'h10, 64'hDEADBEEF_CAFEF00D, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 64'h10, 0, 0, 1);
    check("basic_ld", bus.outputData2, 64'hDEADBEEFCAFEF00D);

    // Intra-bundle ordering
    cyc(0, 64'h20, 64'h1111, 1, 0, 64'h20, 0, 0, 1);
    check("w1r2_fwd", bus.outputData2, 64'h1111);
    cyc(0, 64'h20, 0, 0, 1, 64'h20, 64'h2222, 1, 0);
    check("r1w2_old", bus.outputData1, 64'h1111);
    cyc(0, 64'h20, 0, 0, 1, 0, 0, 0, 0);
    check("r1w2_new", bus.outputData1, 64'h2222);
    cyc(0, 64'h28, 64'hA, 1, 0, 64'h28, 64'hB, 1, 0);
    cyc(0, 0, 0, 0, 0, 64'h28, 0, 0, 1);
    check("w1w2_last", bus.outputData2, 64'hB);

    // Errors, with a concurrent legal slot-2 read
    cyc(0, 64'h0C, 0, 0, 1, 64'h28, 0, 0, 1);
    check("mis_err1", 64'(bus.error1), 64'd1);
    cyc(0, 0, 0, 0, 0, 64'h200, 64'h77, 1, 0);
    check("oor_err2", 64'(bus.error2), 64'd1);
    cyc(0, 64'h10, 64'h99, 1, 1, 0, 0, 0, 0);
    idle(0, 1);

    // Reset mid-sweep, then requests during CLEAR
    idle(1, 1);
    idle(0, 30);
    idle(1, 2);
    idle(0, 10);
    cyc(0, 64'h08, 64'h5, 1, 0, 0, 0, 0, 0);
    idle(0, 60);
    cyc(0, 64'h08, 0, 0, 1, 0, 0, 0, 0);
    check("clr_ignored", bus.outputData1, 64'h0);

    // Reset in READY with a read pending
    cyc(0, 64'h40, 64'h1234, 1, 0, 0, 0, 0, 0);
    cyc(1, 64'h40, 0, 0, 1, 0, 0, 0, 0);
    idle(1, 1);
    idle(0, 64);
    cyc(0, 64'h40, 0, 0, 1, 0, 0, 0, 0);
    check("post_rst_zero", bus.outputData1, 64'h0);

    // Randomized traffic with rare resets
    for (int n = 0; n < 3000; n++) begin
      a1 = rand_addr(); a2 = rand_addr();
      w1 = ($urandom_range(0, 2) == 0); r1 = ($urandom_range(0, 2) == 0);
      w2 = ($urandom_range(0, 2) == 0); r2 = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 599) == 0);
      cyc(rr, a1, {$urandom, $urandom}, w1, r1, a2, {$urandom, $urandom}, w2, r2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
